// File: rtl/usb_piso_tr_arbiter_if.sv
// Bus between the PISO serializer array, the round-robin arbiter and the
// single USB transaction-layer serial-data port.
`ifndef REQUEST_SERIAL_DATA_TYPE_WIDTH
`define REQUEST_SERIAL_DATA_TYPE_WIDTH 2
`endif

interface usb_piso_tr_arbiter_if #(
    parameter int NUMBER_OF_PISO = 4
);
    localparam int TYPE_W = `REQUEST_SERIAL_DATA_TYPE_WIDTH;

    // PISO array side
    logic [NUMBER_OF_PISO-1:0]        piso_data_out;
    logic [NUMBER_OF_PISO-1:0]        piso_data_val;
    logic [NUMBER_OF_PISO-1:0]        piso_data_last;
    logic [NUMBER_OF_PISO-1:0]        piso_serial_data_avail;
    logic [NUMBER_OF_PISO-1:0]        piso_request_serial_data;
    logic [NUMBER_OF_PISO*TYPE_W-1:0] piso_request_serial_data_type;

    // USB_TR side
    logic              usb_tr_piso_data_out;
    logic              usb_tr_piso_data_val;
    logic              usb_tr_piso_data_last;
    logic              usb_tr_piso_serial_data_avail;
    logic              usb_tr_request_serial_data;
    logic [TYPE_W-1:0] usb_tr_request_serial_data_type;

    // Arbiter view
    modport slave (
        input  piso_data_out,
        input  piso_data_val,
        input  piso_data_last,
        input  piso_serial_data_avail,
        input  usb_tr_request_serial_data,
        input  usb_tr_request_serial_data_type,
        output piso_request_serial_data,
        output piso_request_serial_data_type,
        output usb_tr_piso_data_out,
        output usb_tr_piso_data_val,
        output usb_tr_piso_data_last,
        output usb_tr_piso_serial_data_avail
    );

    // Environment view (PISO array plus USB_TR)
    modport master (
        output piso_data_out,
        output piso_data_val,
        output piso_data_last,
        output piso_serial_data_avail,
        output usb_tr_request_serial_data,
        output usb_tr_request_serial_data_type,
        input  piso_request_serial_data,
        input  piso_request_serial_data_type,
        input  usb_tr_piso_data_out,
        input  usb_tr_piso_data_val,
        input  usb_tr_piso_data_last,
        input  usb_tr_piso_serial_data_avail
    );
endinterface

// File: rtl/usb_piso_tr_arbiter.sv
// Round-robin arbiter/sequencer sharing one USB_TR serial-data port between
// NUMBER_OF_PISO serializers. A USB_TR request is forwarded to one PISO with
// data available; that PISO's stream is steered back until its last beat or
// until it stalls for TIMEOUT_CYCLES cycles.
`ifndef REQUEST_SERIAL_DATA_TYPE_WIDTH
`define REQUEST_SERIAL_DATA_TYPE_WIDTH 2
`endif

module usb_piso_tr_arbiter #(
    parameter int NUMBER_OF_PISO = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    // Derived from NUMBER_OF_PISO; leave at its default.
    parameter int GRANT_W        = (NUMBER_OF_PISO > 1) ? $clog2(NUMBER_OF_PISO) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    usb_piso_tr_arbiter_if.slave     bus,
    output logic                     grant_valid,
    output logic [GRANT_W-1:0]       grant_idx,
    output logic                     arb_timeout
);
    localparam int                 TYPE_W   = `REQUEST_SERIAL_DATA_TYPE_WIDTH;
    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(NUMBER_OF_PISO - 1);
    localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [GRANT_W-1:0]         r_grant_idx;
    logic [GRANT_W-1:0]         r_last_grant;
    logic [NUMBER_OF_PISO*TYPE_W-1:0] r_type;
    logic [CNT_W-1:0]           r_timeout_cnt;
    logic                       r_arb_timeout;

    logic [GRANT_W-1:0]         w_search_start;
    logic [GRANT_W-1:0]         w_winner;
    logic                       w_found;
    logic                       w_grant;
    logic                       w_complete;
    logic                       w_timeout;
    logic                       w_sel_data;
    logic                       w_sel_val;
    logic                       w_sel_last;
    logic [NUMBER_OF_PISO-1:0]  w_req_pulse;

    // Round-robin search begins one past the previously served PISO.
    always_comb begin
        if (r_last_grant == LAST_IDX) begin
            w_search_start = '0;
        end else begin
            w_search_start = r_last_grant + GRANT_W'(1);
        end
    end

    // Priority search: first pass covers [start, N-1], second pass wraps to [0, start-1].
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUMBER_OF_PISO; i++) begin
            if (!w_found && bus.piso_serial_data_avail[i] && (GRANT_W'(i) >= w_search_start)) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'(i);
            end
        end
        for (int i = 0; i < NUMBER_OF_PISO; i++) begin
            if (!w_found && bus.piso_serial_data_avail[i]) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'(i);
            end
        end
    end

    // Beat lines of the currently granted PISO; all other PISOs are ignored.
    always_comb begin
        w_sel_data = bus.piso_data_out[r_grant_idx];
        w_sel_val  = bus.piso_data_val[r_grant_idx];
        w_sel_last = bus.piso_data_last[r_grant_idx];
    end

    // Next-state logic; completion takes priority over the stall timeout.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.usb_tr_request_serial_data && w_found) begin
                    w_grant      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_XFER;
            end
            S_XFER: begin
                if (w_sel_val && w_sel_last) begin
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (!w_sel_val && (r_timeout_cnt == CNT_TERM)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant bookkeeping, latched request type, stall counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_idx   <= '0;
            r_last_grant  <= LAST_IDX;
            r_type        <= '0;
            r_timeout_cnt <= '0;
            r_arb_timeout <= 1'b0;
        end else begin
            r_arb_timeout <= w_timeout;

            if (w_grant) begin
                r_grant_idx <= w_winner;
                for (int i = 0; i < NUMBER_OF_PISO; i++) begin
                    r_type[i*TYPE_W +: TYPE_W] <= (w_winner == GRANT_W'(i)) ?
                                                  bus.usb_tr_request_serial_data_type : '0;
                end
            end

            if (w_complete || w_timeout) begin
                r_last_grant <= r_grant_idx;
                r_type       <= '0;
            end

            if ((r_state == S_REQ) || ((r_state == S_XFER) && w_sel_val)) begin
                r_timeout_cnt <= '0;
            end else if (r_state == S_XFER) begin
                r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
            end
        end
    end

    // One-hot request pulse to the granted PISO, present only during REQ.
    always_comb begin
        w_req_pulse = '0;
        for (int i = 0; i < NUMBER_OF_PISO; i++) begin
            w_req_pulse[i] = (r_state == S_REQ) && (r_grant_idx == GRANT_W'(i));
        end
    end

    assign bus.piso_request_serial_data      = w_req_pulse;
    assign bus.piso_request_serial_data_type = r_type;
    assign bus.usb_tr_piso_serial_data_avail = (r_state == S_IDLE) && (|bus.piso_serial_data_avail);
    assign bus.usb_tr_piso_data_out          = (r_state == S_XFER) && w_sel_data;
    assign bus.usb_tr_piso_data_val          = (r_state == S_XFER) && w_sel_val;
    assign bus.usb_tr_piso_data_last         = (r_state == S_XFER) && w_sel_last;

    assign grant_valid = (r_state == S_REQ) || (r_state == S_XFER);
    assign grant_idx   = r_grant_idx;
    assign arb_timeout = r_arb_timeout;

endmodule

// File: tb/tb_usb_piso_tr_arbiter.sv
// Self-checking bench for usb_piso_tr_arbiter: directed scenarios plus
// randomized transfers checked against a round-robin reference model.
`ifndef REQUEST_SERIAL_DATA_TYPE_WIDTH
`define REQUEST_SERIAL_DATA_TYPE_WIDTH 2
`endif

module tb_usb_piso_tr_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int TW = `REQUEST_SERIAL_DATA_TYPE_WIDTH;
    localparam int GW = 2;
    localparam int PW = 1 + GW + 1 + N + N*TW + 1 + 3;

    typedef logic [PW-1:0] obs_t;

    logic          clk;
    logic          rst;
    logic          grant_valid;
    logic [GW-1:0] grant_idx;
    logic          arb_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int m_last;   // model: last PISO served
    int m_grant;  // model: value grant_idx should hold

    initial clk = 1'b0;
    always #5 clk = ~clk;

    usb_piso_tr_arbiter_if #(.NUMBER_OF_PISO(N)) bus ();

    usb_piso_tr_arbiter #(
        .NUMBER_OF_PISO (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .arb_timeout (arb_timeout)
    );

    function automatic obs_t pack(input logic gv, input logic [GW-1:0] gi, input logic to,
                                  input logic [N-1:0] pr, input logic [N*TW-1:0] ty,
                                  input logic av, input logic d, input logic v, input logic l);
        return {gv, gi, to, pr, ty, av, d, v, l};
    endfunction

    function automatic obs_t observe();
        return pack(grant_valid, grant_idx, arb_timeout, bus.piso_request_serial_data,
                    bus.piso_request_serial_data_type, bus.usb_tr_piso_serial_data_avail,
                    bus.usb_tr_piso_data_out, bus.usb_tr_piso_data_val, bus.usb_tr_piso_data_last);
    endfunction

    // Round-robin rule: scan from the PISO after the last one served, wrapping.
    function automatic int pick(input logic [N-1:0] av);
        for (int k = 1; k <= N; k++) begin
            if (av[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last  = N - 1;
        m_grant = 0;
    endtask

    task automatic quiet();
        bus.piso_data_out                   = '0;
        bus.piso_data_val                   = '0;
        bus.piso_data_last                  = '0;
        bus.piso_serial_data_avail          = '0;
        bus.usb_tr_request_serial_data      = 1'b0;
        bus.usb_tr_request_serial_data_type = '0;
    endtask

    task automatic noise();
        bus.piso_data_out          = N'($urandom);
        bus.piso_data_val          = N'($urandom);
        bus.piso_data_last         = N'($urandom);
        bus.piso_serial_data_avail = N'($urandom);
    endtask

    task automatic apply_reset();
        obs_t got, exp;
        @(posedge clk); #1;
        quiet();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = observe();
        exp = pack(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== exp) $display("FAIL reset_state: got %h, expected %h", got, exp);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Request cycle in IDLE, then the REQ cycle. w < 0 means the request is dropped.
    task automatic start_grant(input logic [N-1:0] av, input logic [TW-1:0] ty,
                               output int w, output logic [N*TW-1:0] tyv);
        obs_t got, exp;
        @(posedge clk); #1;
        noise();
        bus.piso_serial_data_avail          = av;
        bus.usb_tr_request_serial_data      = 1'b1;
        bus.usb_tr_request_serial_data_type = ty;
        @(negedge clk);
        got = observe();
        exp = pack(1'b0, GW'(m_grant), 1'b0, '0, '0, |av, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== exp) $display("FAIL idle_req_cycle: got %h, expected %h", got, exp);
        else n_pass++;

        w   = pick(av);
        tyv = '0;
        @(posedge clk); #1;
        noise();
        bus.usb_tr_request_serial_data_type = TW'($urandom);
        if (w < 0) begin
            bus.piso_serial_data_avail     = '0;
            bus.usb_tr_request_serial_data = 1'b0;
        end else begin
            bus.usb_tr_request_serial_data = 1'b1;
            bus.piso_data_val[w]  = 1'b1;
            bus.piso_data_out[w]  = 1'b1;
            bus.piso_data_last[w] = 1'b1;
        end
        @(negedge clk);
        got = observe();
        if (w < 0) begin
            exp = pack(1'b0, GW'(m_grant), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (got !== exp) $display("FAIL dropped_req: got %h, expected %h", got, exp);
            else n_pass++;
        end else begin
            tyv[w*TW +: TW] = ty;
            exp = pack(1'b1, GW'(w), 1'b0, N'(1 << w), tyv, 1'b0, 1'b0, 1'b0, 1'b0);
            m_grant = w;
            n_checks++;
            if (got !== exp) $display("FAIL req_pulse: got %h, expected %h", got, exp);
            else n_pass++;
        end
    endtask

    // XFER cycles: granted PISO sends len beats, others toggle val/last freely.
    task automatic do_beats(input int w, input logic [N*TW-1:0] tyv, input int len,
                            input int first_gap, input int max_gap, input bit poke, input bit finish);
        int   beats = 0;
        int   gap   = first_gap;
        int   cyc   = 0;
        logic d, v, l;
        obs_t got, exp;
        while (beats < len) begin
            @(posedge clk); #1;
            noise();
            if (cyc % 2 == 0) begin
                bus.piso_data_val  = '1;
                bus.piso_data_last = '1;
            end
            bus.usb_tr_request_serial_data      = poke && (cyc % 3 == 1);
            bus.usb_tr_request_serial_data_type = TW'($urandom);
            v = (gap == 0);
            d = 1'($urandom);
            l = v ? (finish && (beats == len - 1)) : 1'($urandom);
            bus.piso_data_val[w]  = v;
            bus.piso_data_out[w]  = d;
            bus.piso_data_last[w] = l;
            if (cyc % 2 == 1) bus.piso_serial_data_avail[w] = 1'b0;
            @(negedge clk);
            got = observe();
            exp = pack(1'b1, GW'(w), 1'b0, '0, tyv, 1'b0, d, v, l);
            n_checks++;
            if (got !== exp) $display("FAIL xfer_beat: got %h, expected %h (cycle %0d)", got, exp, cyc);
            else n_pass++;
            if (v) begin
                beats++;
                gap = int'($urandom_range(max_gap, 0));
            end else begin
                gap--;
            end
            cyc++;
        end
    endtask

    task automatic do_transfer(input logic [N-1:0] av, input logic [TW-1:0] ty, input int len,
                               input int first_gap, input int max_gap, input bit poke);
        int               w;
        logic [N*TW-1:0]  tyv;
        start_grant(av, ty, w, tyv);
        if (w >= 0) begin
            do_beats(w, tyv, len, first_gap, max_gap, poke, 1'b1);
            m_last = w;
        end
    endtask

    task automatic test_reset();
        obs_t got, exp;
        apply_reset();
        @(posedge clk); #1;
        noise();
        bus.piso_serial_data_avail     = 4'b0100;
        bus.usb_tr_request_serial_data = 1'b0;
        @(negedge clk);
        got = observe();
        exp = pack(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== exp) $display("FAIL idle_avail: got %h, expected %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_single();
        obs_t got, exp;
        apply_reset();
        do_transfer(4'b0100, TW'(2), 8, 0, 0, 1'b0);
        @(posedge clk); #1;
        quiet();
        @(negedge clk);
        got = observe();
        exp = pack(1'b0, GW'(2), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== exp) $display("FAIL single_done: got %h, expected %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_transfer(4'b1111, TW'($urandom), 2 + i, 0, 0, 1'b0);
            n_checks++;
            if (grant_idx !== GW'(i % N)) $display("FAIL rr_order: got %0d, expected %0d", grant_idx, i % N);
            else n_pass++;
        end
    endtask

    task automatic test_no_avail();
        do_transfer(4'b0000, TW'(1), 1, 0, 0, 1'b0);
        do_transfer(4'b1000, TW'(3), 6, 1, 2, 1'b1);
    endtask

    task automatic test_timeout();
        int              w;
        logic [N*TW-1:0] tyv;
        logic            d, l;
        logic [7:0]      got4, exp4;
        obs_t            got, exp;
        apply_reset();
        start_grant(4'b1111, TW'(1), w, tyv);
        for (int c = 0; c < TO; c++) begin
            @(posedge clk); #1;
            noise();
            bus.piso_data_val[w] = 1'b0;
            d = bus.piso_data_out[w];
            l = bus.piso_data_last[w];
            @(negedge clk);
            got = observe();
            exp = pack(1'b1, GW'(w), 1'b0, '0, tyv, 1'b0, d, 1'b0, l);
            n_checks++;
            if (got !== exp) $display("FAIL timeout_wait: got %h, expected %h (cycle %0d)", got, exp, c);
            else n_pass++;
        end
        @(posedge clk); #1;
        noise();
        bus.piso_serial_data_avail     = 4'b1111;
        bus.usb_tr_request_serial_data = 1'b0;
        bus.piso_data_val[w]           = 1'b1;
        @(negedge clk);
        got4 = {grant_valid, arb_timeout, bus.usb_tr_piso_serial_data_avail,
                bus.piso_request_serial_data, bus.usb_tr_piso_data_val};
        exp4 = {1'b0, 1'b1, 1'b1, 4'b0000, 1'b0};
        n_checks++;
        if (got4 !== exp4) $display("FAIL timeout_pulse: got %b, expected %b", got4, exp4);
        else n_pass++;
        m_last = w;
        // Last beat lands exactly on the terminal count: completion must win.
        do_transfer(4'b1111, TW'(3), 1, TO - 1, 0, 1'b0);
        @(posedge clk); #1;
        quiet();
        @(negedge clk);
        got = observe();
        exp = pack(1'b0, GW'((w + 1) % N), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== exp) $display("FAIL no_timeout_on_completion: got %h, expected %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid_xfer();
        int              w;
        logic [N*TW-1:0] tyv;
        obs_t            got, exp;
        apply_reset();
        do_transfer(4'b0001, TW'(1), 2, 0, 0, 1'b0);
        start_grant(4'b0010, TW'(2), w, tyv);
        do_beats(w, tyv, 3, 0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        noise();
        bus.piso_data_val[w]  = 1'b1;
        bus.piso_data_last[w] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        noise();
        bus.piso_data_val[w]           = 1'b1;
        bus.piso_data_out[w]           = 1'b1;
        bus.piso_serial_data_avail     = '1;
        bus.usb_tr_request_serial_data = 1'b0;
        @(negedge clk);
        got = observe();
        exp = pack(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== exp) $display("FAIL after_mid_reset: got %h, expected %h", got, exp);
        else n_pass++;
        model_reset();
        do_transfer(4'b1111, TW'(3), 4, 0, 1, 1'b0);
        n_checks++;
        if (grant_idx !== '0) $display("FAIL first_grant_after_reset: got %0d, expected 0", grant_idx);
        else n_pass++;
    endtask

    task automatic test_steering();
        apply_reset();
        do_transfer(4'b0010, TW'(2), 10, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_transfer(N'($urandom), TW'($urandom), int'($urandom_range(10, 1)),
                        int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        quiet();
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_no_avail();
        test_timeout();
        test_reset_mid_xfer();
        test_steering();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_piso_tr_arbiter.md
Name: usb_piso_tr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one USB transaction-layer (USB_TR) serial-data port between NUMBER_OF_PISO PISO serializers.
- On each USB_TR serial-data request, picks one PISO that has data available.
- Forwards the request pulse and request type to that PISO only.
- Steers the winner's serial stream back to USB_TR until its data_last beat.
- Sits between the PISO array and the single USB_TR, in place of a free-running mux.

Parameters:
NUMBER_OF_PISO, 4, number of PISO requesters (>=1)
TIMEOUT_CYCLES, 1024, max cycles in XFER without a valid beat before the transfer is aborted (>=2)
GRANT_W, (NUMBER_OF_PISO>1 ? $clog2(NUMBER_OF_PISO) : 1), width of the grant index (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
piso_data_out  input  NUMBER_OF_PISO  serial data bit per PISO
piso_data_val  input  NUMBER_OF_PISO  data bit valid per PISO
piso_data_last  input  NUMBER_OF_PISO  last bit of packet per PISO
piso_serial_data_avail  input  NUMBER_OF_PISO  PISO holds a packet ready to send
piso_request_serial_data  output  NUMBER_OF_PISO  one-hot single-cycle request pulse to the granted PISO
piso_request_serial_data_type  output  NUMBER_OF_PISO*`REQUEST_SERIAL_DATA_TYPE_WIDTH  per-PISO type slice; slice i = type bits for PISO i
usb_tr_piso_data_out  output  1  steered data bit
usb_tr_piso_data_val  output  1  steered valid
usb_tr_piso_data_last  output  1  steered last
usb_tr_piso_serial_data_avail  output  1  any PISO available, only while IDLE
usb_tr_request_serial_data  input  1  request pulse from USB_TR
usb_tr_request_serial_data_type  input  `REQUEST_SERIAL_DATA_TYPE_WIDTH  request type
grant_valid  output  1  high while in REQ or XFER
grant_idx  output  GRANT_W  index of the current or last granted PISO
arb_timeout  output  1  single-cycle pulse on a timeout abort

Behaviour:
Clock, reset and reset values:
- Single clock. Synchronous active-high reset.
- On reset: state=IDLE; grant_idx=0; last_grant=NUMBER_OF_PISO-1, so the first search starts at PISO 0.
- On reset: piso_request_serial_data=0, piso_request_serial_data_type=0, grant_valid=0, arb_timeout=0, timeout counter=0.

State IDLE:
- usb_tr_piso_serial_data_avail = |piso_serial_data_avail (combinational). It is 0 in every other state.
- If usb_tr_request_serial_data=1 and any avail bit is set:
  - Search starts at last_grant+1, modulo NUMBER_OF_PISO; first set avail bit wins.
  - Register the winner into grant_idx. Latch the type into the winner's slice; all other slices are 0.
  - Next state is REQ.
- A request with no avail bit set is dropped: no state change, no pulse.

State REQ (exactly 1 cycle):
- piso_request_serial_data = one-hot of grant_idx.
- Next state is XFER. Clear the timeout counter.
- Latency: USB_TR request at cycle N produces the PISO request pulse at cycle N+1.

State XFER:
- usb_tr_piso_data_out/val/last = piso_data_*[grant_idx], combinational pass-through with zero added latency.
- piso_request_serial_data=0. Type slice is held until the transfer ends.
- Timeout counter: cleared on each cycle with val[grant_idx]=1, otherwise increments.
- val&last on grant_idx: last_grant<=grant_idx, clear type slices, next state IDLE. The next grant can start 1 cycle later.
- Counter reaches TIMEOUT_CYCLES-1 with no val: pulse arb_timeout, last_grant<=grant_idx, next state IDLE.

Steering and ignored inputs:
- In IDLE and REQ, usb_tr_piso_data_out/val/last are forced to 0.
- Beats from non-granted PISOs are ignored in every state.
- USB_TR requests in REQ or XFER are ignored and are not queued.
- Deassertion of the granted PISO's avail bit during XFER does not end the grant.
- val&last and the timeout terminal count in the same cycle: completion wins, arb_timeout stays 0.

Special cases:
- NUMBER_OF_PISO=1: grant_idx is constantly 0 and the arbitration reduces to an avail check.
- Reset asserted in any state, including mid-XFER: back to IDLE on the next edge with all reset values. The partially sent packet is not resumed.

Test Plan:
1. N=4, reset, avail=4'b0100, request with type=2 -> one cycle later piso_request_serial_data=4'b0100 and slice 2 = 2. After 8 val beats with last on the 8th, usb_tr sees the same 8 bits and returns to IDLE; grant_idx=2.
2. avail=4'b1111, four back-to-back packets -> grants in order 0,1,2,3, then 0 again. No PISO is granted twice in a row while others are pending.
3. Request with avail=0 -> no request pulse, state stays IDLE. A request during XFER -> no second pulse, the grant is unchanged.
4. TIMEOUT_CYCLES=16, granted PISO never asserts val -> arb_timeout pulses 16 cycles after entering XFER, return to IDLE, the next grant goes to grant_idx+1.
5. rst asserted mid-XFER after 3 beats -> next cycle all outputs are 0, state IDLE, and the first subsequent grant goes to PISO 0.
6. During XFER to PISO 1, PISO 3 toggles val/last and PISO 1 drops avail -> usb_tr outputs track only PISO 1, and the transfer ends only on PISO 1 val&last.
